motor_drive_sequencer: RTL and testbench
========================================

# motor_drive_sequencer

Sequences the 3-bit drive-mode input (UI) of the hall-sensor commutation controller from host commands decoded off the UART. Commands are accepted over a valid/ready handshake. A coast dwell is enforced between any two non-coast drive modes, and direction reversals are routed through a timed regenerative brake. Invalid hall codes, and optionally a stalled rotor, latch a fault that coasts the motor until cleared.

## Interface
Parameters:
- DEAD_CYCLES, 1000 — coast dwell length (cycles), ≥1
- BRAKE_CYCLES, 50000 — reversal brake length (cycles), ≥1
- STALL_CYCLES, 1000000 — stall watchdog limit (cycles), ≥2
- CNT_W, 24 — counter width; must hold the largest of the three parameters

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd  in  2  00 coast, 01 cw, 10 ccw, 11 brake
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge clk
- HS  in  3  raw hall sensors (asynchronous)
- fault_clr  in  1  leaves FAULT (level, sampled)
- UI  out  3  to commutation controller: 000 coast, 010 cw, 100 ccw, 001 brake
- state  out  3  current state encoding (below)
- fault  out  1  high while in FAULT

## Operation
- HS passes through a 2-flop synchronizer; all hall logic uses the synchronized value hs_s.
- States and encodings: COAST=0 (UI 000), CW=1 (010), CCW=2 (100), BRAKE=3 (001, held), REVBRK=4 (001, timed), DWELL=5 (000, timed), FAULT=6 (000).
- cmd_ready = 1 in COAST, CW, CCW and BRAKE; 0 in DWELL, REVBRK and FAULT; 0 during rst.
- The target mode is stored in a pending register plus a reversal flag.
- Accepted coast: any ready state goes to COAST immediately.
- Accepted cw/ccw/brake equal to the current mode: no-op.
- Accepted cw/ccw/brake from COAST: go to DWELL, then to the target.
- Accepted cw/ccw/brake from a non-zero mode, except a reversal: go to DWELL, then to the target.
- Reversal (CW→ccw or CCW→cw): DWELL, then REVBRK, then DWELL, then the target.
- UI never switches directly between two different non-zero values.
- DWELL lasts exactly DEAD_CYCLES cycles; REVBRK lasts exactly BRAKE_CYCLES cycles. The counter loads on state entry and decrements; the exit occurs on the cycle it reaches 1.
- Invalid hall: in CW, CCW or REVBRK, an hs_s value of 000 or 111 sends the block to FAULT on the next edge. This check has priority over command acceptance and timer expiry.
- FAULT: UI=000 and commands are ignored. fault_clr=1 goes to COAST, clears pending and the watchdog, and drops fault.
- rst=1 (at any time, including mid-DWELL/REVBRK): state=COAST, UI=000, fault=0, counters=0, pending cleared, synchronizer flops=0.

## Timing
- state, UI and fault are registered and change on the same edge.
- Command accepted at edge E: the new state and UI are visible immediately after E.
- Time from cw acceptance at E to UI=010: DEAD_CYCLES edges after E.
- Time from reversal acceptance to the new direction: 2·DEAD_CYCLES+BRAKE_CYCLES cycles.
- Hall input to fault detection: 2 cycles of sync plus 1 cycle of decision = 3 cycles.
- cmd_valid may be held across ready-low periods; the command is taken on the first ready edge.

## Configuration
- DRIVE_STALL_WDT_EN defined:
  - A CNT_W-bit watchdog clears on any change of hs_s, and in every state other than CW/CCW.
  - Otherwise, in CW/CCW it increments each cycle.
  - On reaching STALL_CYCLES it forces FAULT on the next edge.
- Not defined: no watchdog logic; FAULT is entered only on an invalid hall code.

## Test plan
Bench parameters: DEAD_CYCLES=4, BRAKE_CYCLES=8, STALL_CYCLES=16; hall inputs stepped every 5 cycles through 101→100→110→010→011→001.
- Reset then cw: rst for 2 cycles, then cmd=01 → UI=000 for 4 cycles, then UI=010; cmd_ready=0 during DWELL.
- CW→ccw reversal: cmd=10 while in CW → UI 000×4, then 001×8, then 000×4, then 100; UI never goes 010→100 directly.
- Coast from CCW and brake: cmd=00 → UI=000 on the next edge; then cmd=11 → DWELL 4 cycles, then UI=001 held indefinitely.
- Invalid hall: HS=111 during CW → fault=1 and UI=000 within 3 cycles; cmd_valid is ignored; fault_clr=1 → state=COAST, fault=0.
- Reset mid-REVBRK: rst pulsed at the 3rd brake cycle → UI=000, state=0 the next cycle; no pending reversal resumes.
- Stall (DRIVE_STALL_WDT_EN): HS frozen at 101 in CW → FAULT after 16 cycles. Without the macro, the same stimulus stays in CW for 100 cycles.

Source files
------------

// File: rtl/motor_drive_sequencer.sv
// Drive-mode sequencer for the hall commutation controller: coast dwell, timed reversal brake, hall fault latch.
// Define DRIVE_STALL_WDT_EN to add the stalled-rotor watchdog.
module motor_drive_sequencer #(
    parameter int DEAD_CYCLES  = 1000,
    parameter int BRAKE_CYCLES = 50000,
    parameter int STALL_CYCLES = 1000000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic [2:0] HS,
    input  logic       fault_clr,
    output logic [2:0] UI,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        COAST  = 3'd0,
        CW     = 3'd1,
        CCW    = 3'd2,
        BRAKE  = 3'd3,
        REVBRK = 3'd4,
        DWELL  = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Bad parameter sets would silently truncate the timers, so stop elaboration instead.
    if (DEAD_CYCLES < 1 || BRAKE_CYCLES < 1 || STALL_CYCLES < 2 || CNT_W < 1 || CNT_W > 30 ||
        DEAD_CYCLES >= (1 << CNT_W) || BRAKE_CYCLES >= (1 << CNT_W) ||
        STALL_CYCLES >= (1 << CNT_W)) begin : g_param_check
        $error("motor_drive_sequencer: invalid timing parameters for CNT_W");
    end

    state_t           cur_state;
    state_t           nxt_state;
    state_t           pend_mode;
    state_t           nxt_pend_mode;
    state_t           cmd_mode;
    logic             pend_rev;
    logic             nxt_pend_rev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [2:0]       nxt_ui;
    logic [2:0]       hs_meta;
    logic [2:0]       hs_s;
    logic             ready_state;
    logic             accept;
    logic             hall_bad;
    logic             stall;
    logic             is_reversal;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_meta <= 3'b000;
            hs_s    <= 3'b000;
        end else begin
            hs_meta <= HS;
            hs_s    <= hs_meta;
        end
    end

`ifdef DRIVE_STALL_WDT_EN
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_CYCLES);

    logic [CNT_W-1:0] wdt;
    logic [2:0]       hs_prev;

    // Any hall edge proves the rotor is turning; outside CW/CCW there is nothing to watch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt     <= '0;
            hs_prev <= 3'b000;
        end else begin
            hs_prev <= hs_s;
            if (!(cur_state inside {CW, CCW}) || (hs_s != hs_prev)) begin
                wdt <= '0;
            end else if (wdt != STALL_LIMIT) begin
                wdt <= wdt + CNT_ONE;
            end
        end
    end

    assign stall = (wdt == STALL_LIMIT);
`else
    assign stall = 1'b0;
`endif

    assign ready_state = cur_state inside {COAST, CW, CCW, BRAKE};
    assign cmd_ready   = ready_state && !rst;
    assign accept      = cmd_valid && ready_state;
    assign hall_bad    = (cur_state inside {CW, CCW, REVBRK}) && ((hs_s == 3'b000) || (hs_s == 3'b111));
    assign is_reversal = ((cur_state == CW) && (cmd_mode == CCW)) || ((cur_state == CCW) && (cmd_mode == CW));

    always_comb begin
        cmd_mode = COAST;
        case (cmd)
            2'b01:   cmd_mode = CW;
            2'b10:   cmd_mode = CCW;
            2'b11:   cmd_mode = BRAKE;
            default: cmd_mode = COAST;
        endcase
    end

    // Fault detection outranks both command acceptance and timer expiry.
    always_comb begin
        nxt_state     = cur_state;
        nxt_pend_mode = pend_mode;
        nxt_pend_rev  = pend_rev;
        nxt_cnt       = cnt;

        if (hall_bad || stall) begin
            nxt_state     = FAULT;
            nxt_pend_mode = COAST;
            nxt_pend_rev  = 1'b0;
            nxt_cnt       = '0;
        end else begin
            case (cur_state)
                COAST, CW, CCW, BRAKE: begin
                    if (accept) begin
                        if (cmd_mode == COAST) begin
                            nxt_state = COAST;
                        end else if (cmd_mode != cur_state) begin
                            nxt_state     = DWELL;
                            nxt_cnt       = DEAD_LOAD;
                            nxt_pend_mode = cmd_mode;
                            nxt_pend_rev  = is_reversal;
                        end
                    end
                end
                DWELL: begin
                    if (cnt <= CNT_ONE) begin
                        if (pend_rev) begin
                            nxt_state    = REVBRK;
                            nxt_cnt      = BRAKE_LOAD;
                            nxt_pend_rev = 1'b0;
                        end else begin
                            nxt_state     = pend_mode;
                            nxt_cnt       = '0;
                            nxt_pend_mode = COAST;
                        end
                    end else begin
                        nxt_cnt = cnt - CNT_ONE;
                    end
                end
                REVBRK: begin
                    if (cnt <= CNT_ONE) begin
                        nxt_state = DWELL;
                        nxt_cnt   = DEAD_LOAD;
                    end else begin
                        nxt_cnt = cnt - CNT_ONE;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        nxt_state     = COAST;
                        nxt_pend_mode = COAST;
                        nxt_pend_rev  = 1'b0;
                        nxt_cnt       = '0;
                    end
                end
                default: begin
                    nxt_state     = COAST;
                    nxt_pend_mode = COAST;
                    nxt_pend_rev  = 1'b0;
                    nxt_cnt       = '0;
                end
            endcase
        end
    end

    always_comb begin
        nxt_ui = 3'b000;
        case (nxt_state)
            CW:            nxt_ui = 3'b010;
            CCW:           nxt_ui = 3'b100;
            BRAKE, REVBRK: nxt_ui = 3'b001;
            default:       nxt_ui = 3'b000;
        endcase
    end

    // UI and fault are registered alongside the state so all three move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= COAST;
            pend_mode <= COAST;
            pend_rev  <= 1'b0;
            cnt       <= '0;
            UI        <= 3'b000;
            fault     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            pend_mode <= nxt_pend_mode;
            pend_rev  <= nxt_pend_rev;
            cnt       <= nxt_cnt;
            UI        <= nxt_ui;
            fault     <= (nxt_state == FAULT);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: vector table, corner-case sequences, and random traffic
// checked against a schedule-queue reference model.
module tb_motor_drive_sequencer;

    localparam int DEAD  = 4;
    localparam int BRAKE = 8;
    localparam int STALL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic [2:0] HS = 3'b101;
    logic       fault_clr = 1'b0;
    logic [2:0] UI;
    logic [2:0] state;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    motor_drive_sequencer #(
        .DEAD_CYCLES (DEAD),
        .BRAKE_CYCLES(BRAKE),
        .STALL_CYCLES(STALL),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .HS       (HS),
        .fault_clr(fault_clr),
        .UI       (UI),
        .state    (state),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Reference model: the future state sequence is planned as a queue when a command is taken.
    int         m_state = 0;
    int         plan[$];
    logic [2:0] m_meta = 3'b000;
    logic [2:0] m_hs   = 3'b000;
    logic       m_rst  = 1'b1;

    function automatic logic [2:0] ui_of(input int s);
        case (s)
            1:       return 3'b010;
            2:       return 3'b100;
            3, 4:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic model_ready();
        return !m_rst && (plan.size() == 0) && (m_state <= 3);
    endfunction

    task automatic modelStep(input logic r, input logic v, input logic [1:0] c, input logic [2:0] h,
                             input logic clr);
        int  tgt;
        logic bad;
        m_rst = r;
        if (r) begin
            m_state = 0;
            plan.delete();
            m_meta = 3'b000;
            m_hs   = 3'b000;
        end else begin
            bad = (m_state inside {1, 2, 4}) && (m_hs == 3'b000 || m_hs == 3'b111);
            if (bad) begin
                m_state = 6;
                plan.delete();
            end else if (plan.size() != 0) begin
                m_state = plan.pop_front();
            end else if (m_state == 6) begin
                if (clr) m_state = 0;
            end else if (v) begin
                tgt = int'(c);
                if (tgt == 0) begin
                    m_state = 0;
                end else if (tgt != m_state) begin
                    repeat (DEAD) plan.push_back(5);
                    if ((m_state == 1 && tgt == 2) || (m_state == 2 && tgt == 1)) begin
                        repeat (BRAKE) plan.push_back(4);
                        repeat (DEAD) plan.push_back(5);
                    end
                    plan.push_back(tgt);
                    m_state = plan.pop_front();
                end
            end
            m_hs   = m_meta;
            m_meta = h;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] c, input logic [2:0] h,
                                 input logic clr);
        rst       = r;
        cmd_valid = v;
        cmd       = c;
        HS        = h;
        fault_clr = clr;
        modelStep(r, v, c, h, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int es, input logic [2:0] eui, input logic ef,
                               input logic erdy);
        logic [2:0] es_l;
        es_l = 3'(es);
        checks++;
        if ({state, UI, fault, cmd_ready} !== {es_l, eui, ef, erdy}) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d UI=%b fault=%b ready=%b, want state=%0d UI=%b fault=%b ready=%b",
                     name, state, UI, fault, cmd_ready, es_l, eui, ef, erdy);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
        end
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] c;
        logic       clr;
        int         es;
        logic [2:0] eui;
        logic       ef;
        logic       erdy;
    } vec_t;

    vec_t       vecs[16];
    logic [2:0] hall_seq[6];

    initial begin
        int n;
        int bad_cycles;
        int direct;
        int es;
        logic [2:0] prev_ui;
        logic [2:0] eui;
        logic [2:0] h;
        int hidx;
        logic v;
        logic r;
        logic clr;
        logic [1:0] c;

        hall_seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

        // Reset, cw through dwell, no-op, coast, brake through dwell, held brake.
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 0, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 0, 3'b000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1, 3'b010, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1, 3'b010, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 0, 3'b000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 5, 3'b000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 3'b001, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 1'b0, 3, 3'b001, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 2'b11, 1'b0, 3, 3'b001, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].c, 3'b101, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].eui, vecs[i].ef, vecs[i].erdy);
        end

        // BRAKE -> cw, then CW -> ccw reversal.
        applyStimulus(1'b0, 1'b1, 2'b01, 3'b101, 1'b0);
        repeat (DEAD - 1) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("brake_to_cw_last_dwell", 5, 3'b000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("brake_to_cw", 1, 3'b010, 1'b0, 1'b1);

        direct  = 0;
        prev_ui = UI;
        for (int i = 0; i <= 2 * DEAD + BRAKE; i++) begin
            applyStimulus(1'b0, (i == 0), (i == 0) ? 2'b10 : 2'b00, 3'b101, 1'b0);
            if (i < DEAD)              begin es = 5; eui = 3'b000; end
            else if (i < DEAD + BRAKE) begin es = 4; eui = 3'b001; end
            else if (i < 2 * DEAD + BRAKE) begin es = 5; eui = 3'b000; end
            else                       begin es = 2; eui = 3'b100; end
            checkOutput($sformatf("reversal_step%0d", i), es, eui, 1'b0, (i == 2 * DEAD + BRAKE));
            if (prev_ui != 3'b000 && UI != 3'b000 && prev_ui != UI) direct++;
            prev_ui = UI;
        end
        checkValue("reversal_direct_switches", direct, 0, 0);

        // Coast from CCW, then brake held.
        applyStimulus(1'b0, 1'b1, 2'b00, 3'b101, 1'b0);
        checkOutput("ccw_to_coast", 0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b11, 3'b101, 1'b0);
        checkOutput("coast_to_brake_dwell", 5, 3'b000, 1'b0, 1'b0);
        repeat (DEAD - 1) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
            checkOutput($sformatf("brake_hold%0d", i), 3, 3'b001, 1'b0, 1'b1);
        end

        // Invalid hall in CW, commands ignored in FAULT, then clear.
        applyStimulus(1'b0, 1'b1, 2'b01, 3'b101, 1'b0);
        repeat (DEAD) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("hall_setup_cw", 1, 3'b010, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b111, 1'b0);
        checkOutput("hall_bad_edge1", 1, 3'b010, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b111, 1'b0);
        checkOutput("hall_bad_edge2", 1, 3'b010, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b111, 1'b0);
        checkOutput("hall_bad_edge3", 6, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b01, 3'b101, 1'b0);
            checkOutput($sformatf("fault_ignores_cmd%0d", i), 6, 3'b000, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b1);
        checkOutput("fault_clear", 0, 3'b000, 1'b0, 1'b1);

        // Reset during the third REVBRK cycle; the reversal must not resume.
        applyStimulus(1'b0, 1'b1, 2'b01, 3'b101, 1'b0);
        repeat (DEAD) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("rst_setup_cw", 1, 3'b010, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b10, 3'b101, 1'b0);
        repeat (DEAD - 1 + 3) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("rst_third_brake_cycle", 4, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("rst_mid_revbrk", 0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
            checkOutput($sformatf("post_rst_idle%0d", i), 0, 3'b000, 1'b0, 1'b1);
        end

        // Frozen hall in CW.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b101, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 3'b101, 1'b0);
        repeat (DEAD) applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("stall_setup_cw", 1, 3'b010, 1'b0, 1'b1);
`ifdef DRIVE_STALL_WDT_EN
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
            if (fault === 1'b1) n = i;
        end
        checkValue("stall_fault_latency", n, STALL, STALL + 2);
        checkOutput("stall_fault_state", 6, 3'b000, 1'b1, 1'b0);
`else
        bad_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 3'b101, 1'b0);
            if (state !== 3'd1 || UI !== 3'b010 || fault !== 1'b0) bad_cycles++;
        end
        checkValue("no_wdt_cycles_out_of_cw", bad_cycles, 0, 0);
`endif

        // Random traffic against the reference model.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("rand_reset0", m_state, ui_of(m_state), (m_state == 6), model_ready());
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b101, 1'b0);
        checkOutput("rand_reset1", m_state, ui_of(m_state), (m_state == 6), model_ready());
        hidx = 0;
        h    = hall_seq[0];
        for (int i = 0; i < 700; i++) begin
            if (i % 5 == 0) begin
                hidx = (hidx + 1) % 6;
                if ($urandom_range(0, 11) == 0) h = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
                else h = hall_seq[hidx];
            end
            r   = ($urandom_range(0, 99) == 0);
            v   = ($urandom_range(0, 2) == 0);
            c   = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 9) == 0);
            applyStimulus(r, v, c, h, clr);
            checkOutput($sformatf("rand%0d", i), m_state, ui_of(m_state), (m_state == 6), model_ready());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
